// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and constants.
// State encoding of the elastic two-entry stage, plus the default bubble instruction
// that the ID/EX bubble logic also uses.
package pipe_pkg;

  // Occupancy of a two-entry elastic stage: nothing, main only, main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Instruction word presented while a stage holds nothing valid.
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter for performance debug.
// Latency: count reflects an inc one cycle after the edge that samples it.
// Backpressure: none; holds at all-ones instead of wrapping, cleared only by reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count qualifying cycles, sticking at the maximum value.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeir_elastic.sv
// Two-entry elastic IF/ID stage (main + skid) with flush and perf counters.
// Latency: 1 cycle from an accepted input to out_valid.
// Backpressure: in_ready comes from registered occupancy only; skid absorbs one stalled beat.
module pipeir_elastic
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_INST = DATA_W'(NOP_INST_DEFAULT),
  parameter int                 CNT_W    = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [DATA_W-1:0] in_inst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc4,
  output logic [DATA_W-1:0] out_inst,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_t       state;
  logic [DATA_W-1:0] main_pc4;
  logic [DATA_W-1:0] main_inst;
  logic [DATA_W-1:0] skid_pc4;
  logic [DATA_W-1:0] skid_inst;
  logic              in_xfer;
  logic              out_xfer;

  // Readiness depends only on the stored occupancy, so ID stalls never reach IF combinationally.
  assign in_ready  = resetn & (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // ID always sees the oldest entry; the skid never bypasses main.
  assign out_pc4   = main_pc4;
  assign out_inst  = main_inst;

  // Occupancy FSM and entry registers; flush drops everything held and the incoming beat.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= EMPTY;
      main_pc4  <= '0;
      main_inst <= NOP_INST;
      skid_pc4  <= '0;
      skid_inst <= '0;
    end else if (flush) begin
      // pc4 is left as-is; ID qualifies it with out_valid.
      state     <= EMPTY;
      main_inst <= NOP_INST;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_pc4  <= in_pc4;
            main_inst <= in_inst;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_pc4  <= in_pc4;
            main_inst <= in_inst;
          end else if (in_xfer) begin
            skid_pc4  <= in_pc4;
            skid_inst <= in_inst;
            state     <= FULL;
          end else if (out_xfer) begin
            main_inst <= NOP_INST;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_pc4  <= skid_pc4;
            main_inst <= skid_inst;
            state     <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock  (clock),
    .resetn (resetn),
    .inc    (flush),
    .count  (flush_cnt)
  );

  // A bubble is a cycle where ID was willing to consume but nothing was offered.
  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clock  (clock),
    .resetn (resetn),
    .inc    (~out_valid & out_ready),
    .count  (bubble_cnt)
  );

endmodule

// File: doc/pipeir_elastic.md
Name: pipeir_elastic

Overview:
- Parametrised successor of the fixed IF/ID latch: a two-entry elastic IF/ID stage with a valid/ready handshake.
- The second entry is a skid register, so back-pressure from ID never creates a combinational path back to IF.
- Supports a flush (control-hazard bubble) with a configurable NOP encoding.
- Keeps saturating counters of flushes and bubble cycles for performance debug.
- Sits between the fetch unit (PC/IMEM) and the decode/register-file stage.

Parameters:
- DATA_W, 32, width of the pc4 and instruction fields.
- NOP_INST, 32'h0000_0000, instruction value presented on out_inst when the stage holds no valid instruction.
- CNT_W, 16, width of each performance counter.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  synchronous active-low reset.
- in_valid  in  1  fetch presents pc4/inst.
- in_ready  out  1  stage can accept this cycle.
- in_pc4  in  DATA_W  PC+4 from IF.
- in_inst  in  DATA_W  fetched instruction.
- flush  in  1  control hazard; discard all held and incoming instructions.
- out_valid  out  1  out_pc4/out_inst valid for ID.
- out_ready  in  1  ID consumes this cycle (0 = stall, replaces legacy wpcir).
- out_pc4  out  DATA_W  PC+4 to ID.
- out_inst  out  DATA_W  instruction to ID.
- flush_cnt  out  CNT_W  number of cycles with flush=1, saturating.
- bubble_cnt  out  CNT_W  number of cycles with out_valid=0 and out_ready=1, saturating.

Behaviour:
- Reset is synchronous: on a clock edge with resetn=0 the block enters the following state, overriding all other inputs.
  - state=EMPTY, out_valid=0, out_pc4=0, out_inst=NOP_INST, skid register=0, flush_cnt=0, bubble_cnt=0.
  - in_ready=0 while resetn=0; after reset in_ready=1.
  - Reset mid-transfer loses both entries; no partial state survives.
- Handshake events:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Latency from input transfer to out_valid is 1 cycle.
- in_ready = (state != FULL). It is decoded from registered state only; there is no combinational path from out_ready or in_valid.
- State machine (EMPTY: 0 entries, ONE: main only, FULL: main+skid):
  - EMPTY: input transfer -> main<=in, ONE; otherwise stay.
  - ONE, input and output transfer -> main<=in, stay ONE.
  - ONE, input transfer and out_ready=0 -> skid<=in, FULL.
  - ONE, no input transfer and output transfer -> EMPTY.
  - ONE, neither transfer -> hold.
  - FULL: out_ready=1 -> main<=skid, ONE; otherwise hold. No input is accepted in FULL.
- Ordering: entries leave strictly in arrival order. The skid contents never bypass main.
- out_valid=1 exactly in states ONE and FULL. out_pc4/out_inst always come from main.
- Entering EMPTY (output drain or flush):
  - out_inst<=NOP_INST.
  - out_pc4 retains its last value; ID must qualify out_pc4 with out_valid.
- Flush:
  - Highest priority below reset: next state=EMPTY, out_valid=0, out_inst=NOP_INST.
  - The skid entry is discarded.
  - An input transfer in the flush cycle (in_valid & in_ready) counts as consumed by the stage and is dropped. IF must redirect its PC in the same cycle.
  - An output transfer in the flush cycle still counts as completed for ID.
  - flush asserted in EMPTY: no state change; flush_cnt still increments.
- Counters:
  - Increment by 1 on each qualifying cycle.
  - Saturate at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- Width rules: DATA_W >= 1. All data paths are pure registers; no arithmetic on pc4.

Decomposition:
- Shared package pipe_pkg:
  - state enum {EMPTY, ONE, FULL} (2 bits).
  - default NOP_INST constant, shared with the ID/EX bubble logic.
- Natural sub-module: sat_counter (parameter CNT_W; ports clock, resetn, inc, count). It is instantiated twice here and reused by later stages.

Test Plan:
- Reset then stream: resetn=0 for 2 cycles, then in_valid=1 with inst=0x20010005, 0x20020007, out_ready=1 -> out_valid rises 1 cycle after each input transfer; out_inst shows 0x20010005 then 0x20020007; in_ready stays 1; bubble_cnt=1 (first empty cycle).
- Stall into skid: present A=0x11, B=0x22 on consecutive cycles with out_ready=0 -> state FULL, in_ready=0, out_inst=0x11. Raise out_ready -> 0x11 then 0x22 delivered in order; in_ready returns 1 one cycle after FULL exits.
- Flush while FULL with in_valid=1: flush=1 for one cycle -> next cycle out_valid=0, out_inst=NOP_INST, state EMPTY; skid and incoming inst never appear; flush_cnt increments by 1.
- Flush while ONE with an input transfer (inst 0x33): flush=1 -> 0x33 dropped, out_valid=0 next cycle, out_pc4 unchanged.
- Mid-operation reset: state FULL, resetn=0 for one edge -> all outputs at reset values; both counters 0; in_ready=0 during reset and 1 after.
- Saturation with CNT_W=4: hold out_valid=0, out_ready=1 for 20 cycles -> bubble_cnt stops at 15; flush held 20 cycles -> flush_cnt=15.
